paddle_ctrl: RTL
================

// Module: paddle_ctrl
// PURPOSE
//  Upstream feeder of the ball controller. Turns two raw player buttons into a
//  debounced, rate-limited, clamped paddle-centre tile position (o_Paddle_Pos).
//  The ball controller consumes o_Paddle_Pos. The block also produces the
//  registered paddle draw strobe for the VGA pixel mux.
//  Tile convention matches the ball: tile n covers pixels ((n-1)*PIXEL_SIZE, n*PIXEL_SIZE), both bounds exclusive.
// PARAMETERS
//  HMAX 800             h counter range (sets i_H_count width)
//  VMAX 525             v counter range (sets i_V_count width)
//  WIDTH 40             playfield tiles horizontally (sets o_Paddle_Pos width)
//  HEIGHT 30            playfield tiles vertically
//  PIXEL_SIZE 16        pixels per tile edge
//  PADDLE_H_POS 5       tile column the paddle is drawn in
//  PADDLE_HALF 3        paddle spans tiles pos-PADDLE_HALF..pos+PADDLE_HALF (7 tiles)
//  TOP_POS_MIN 1        top playfield tile
//  BOT_POS_MAX 30       bottom playfield tile
//  P_INIT 15            centre tile after reset
//  DEBOUNCE_CYCLES 250000  stable cycles required before a button level is accepted
//  MOVE_SPEED 1250000   cycles between steps while a button is held
// PORTS
//  i_Clk            in   1                     system/pixel clock
//  i_Reset          in   1                     async, active-high reset
//  i_Up_Raw         in   1                     raw up button, asynchronous, active-high
//  i_Down_Raw       in   1                     raw down button, asynchronous, active-high
//  i_Game_Active    in   1                     1 = movement enabled; 0 = paddle frozen
//  i_H_count        in   $clog2(HMAX)          current pixel column
//  i_V_count        in   $clog2(VMAX)          current pixel row
//  o_Paddle_Pos     out  $clog2(WIDTH)         paddle centre tile (ball controller input)
//  o_Draw_Paddle    out  1                     1 = current pixel belongs to the paddle
// BEHAVIOUR
//  Reset (async, i_Reset=1): o_Paddle_Pos=P_INIT, o_Draw_Paddle=0.
//   Also forces debouncers to released, FSM to IDLE and step counter to 0.
//  Debounce: each raw button is 2-flop synchronised. The debounced level changes only after
//   the synced level differs from it for DEBOUNCE_CYCLES consecutive cycles.
//   Any bounce restarts the count.
//  Request: up_req = dbU & ~dbD, dn_req = dbD & ~dbU. Both or neither pressed = no request.
//  FSM (one-hot or 2-bit, registered):
//   IDLE: counter=0. Go to STEP when (up_req|dn_req) & i_Game_Active.
//   STEP: single cycle. Applies one step, then goes to HOLD.
//         up: pos-1; dn: pos+1. The request is sampled in this cycle.
//   HOLD: counter increments every cycle. When it reaches MOVE_SPEED-1 it clears to 0
//         and the FSM goes to STEP.
//         Goes to IDLE immediately (counter=0) if the request drops, the request
//         direction flips, or i_Game_Active=0.
//  Step latency: debounced press -> pos change is 2 cycles (IDLE->STEP->update).
//   While held, steps repeat every MOVE_SPEED+1 cycles.
//  Clamp: pos is never < TOP_POS_MIN+PADDLE_HALF (4) or > BOT_POS_MAX-PADDLE_HALF (27).
//   A step that would leave that range is dropped, but the FSM still cycles normally.
//  i_Game_Active=0: pos holds its value. It is not recentred except by i_Reset.
//  Draw (registered, 1-cycle latency from i_H_count/i_V_count):
//   1 iff  (PADDLE_H_POS-1)*PIXEL_SIZE < i_H_count < PADDLE_H_POS*PIXEL_SIZE
//   and    (pos-PADDLE_HALF-1)*PIXEL_SIZE < i_V_count < (pos+PADDLE_HALF)*PIXEL_SIZE.
//   Compute the bounds at the counter widths plus 1 bit so there is no underflow at pos=4.
//   Draw uses the registered pos. The draw output is independent of i_Game_Active.
//  Simultaneous events: an edge on i_Game_Active in the same cycle as STEP does not
//   cancel that step. Reset mid-HOLD restarts from IDLE and P_INIT.
// STRUCTURE
//  Shared package (pong_pkg): tile/pixel constants (PIXEL_SIZE, WIDTH, HEIGHT,
//   TOP_POS_MIN, BOT_POS_MAX) and the paddle FSM state encodings, so ball_ctrl and
//   paddle_ctrl agree on geometry.
//  Sub-module: button_debounce (sync + stable counter, param DEBOUNCE_CYCLES),
//   instantiated twice. The FSM, clamp and draw logic stay in paddle_ctrl.
// TESTING  (DEBOUNCE_CYCLES=4, MOVE_SPEED=8)
//  1 Reset asserted mid-run -> o_Paddle_Pos=15 and o_Draw_Paddle=0 the same cycle (async).
//  2 Up bounce (1-2-1 cycle pulses), then held -> pos stays 15 through the bounces.
//    Single step to 14, 2 cycles after debounce, then 13 nine cycles later.
//  3 Down held for 300 cycles from 15 -> pos stops at 27 and never exceeds it.
//    Up held from 27 -> pos stops at 4.
//  4 Up and down both held -> pos unchanged. Release down -> stepping up begins
//    from IDLE with a fresh counter.
//  5 i_Game_Active=0 mid-HOLD -> FSM goes to IDLE and pos is frozen.
//    Re-enable with up still held -> immediate step.
//  6 Sweep H/V with pos=15 -> o_Draw_Paddle=1 exactly for H 65..79 and V 177..287,
//    one cycle after the counts are applied.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: geometry shared by the ball and paddle controllers, plus the
// paddle FSM state encoding. Both controllers import this package so that
// they agree on tile size and playfield extent.
package pong_pkg;

    localparam int PIXEL_SIZE  = 16;  // pixels per tile edge
    localparam int WIDTH       = 40;  // playfield tiles horizontally
    localparam int HEIGHT      = 30;  // playfield tiles vertically
    localparam int TOP_POS_MIN = 1;   // top playfield tile
    localparam int BOT_POS_MAX = 30;  // bottom playfield tile

    typedef enum logic [1:0] {
        PADDLE_IDLE = 2'd0,
        PADDLE_STEP = 2'd1,
        PADDLE_HOLD = 2'd2
    } paddle_state_t;

endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchroniser followed by a stable-level filter.
// The output level follows the synchronised input only after the two have
// differed for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
// Ports:
//   i_Clk    in   clock
//   i_Reset  in   async active-high reset (output forced to released)
//   i_Raw    in   raw asynchronous button, active-high
//   o_Level  out  debounced level
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Raw,
    output logic o_Level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_meta;
    logic          r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta <= i_Raw;
            r_sync <= r_meta;
            if (r_sync == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                // this is the Nth consecutive differing cycle
                r_level <= r_sync;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_Level = r_level;

endmodule

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: turns two raw buttons into a debounced, rate-limited, clamped
// paddle-centre tile position and a registered paddle draw strobe.
// Ports:
//   i_Clk          in   pixel/system clock
//   i_Reset        in   async active-high reset
//   i_Up_Raw       in   raw up button
//   i_Down_Raw     in   raw down button
//   i_Game_Active  in   1 = movement enabled
//   i_H_count      in   current pixel column
//   i_V_count      in   current pixel row
//   o_Paddle_Pos   out  paddle centre tile (feeds the ball controller)
//   o_Draw_Paddle  out  1 = current pixel is paddle (1-cycle latency)
module paddle_ctrl #(
    parameter int HMAX            = 800,
    parameter int VMAX            = 525,
    parameter int WIDTH           = pong_pkg::WIDTH,
    parameter int HEIGHT          = pong_pkg::HEIGHT,
    parameter int PIXEL_SIZE      = pong_pkg::PIXEL_SIZE,
    parameter int PADDLE_H_POS    = 5,
    parameter int PADDLE_HALF     = 3,
    parameter int TOP_POS_MIN     = pong_pkg::TOP_POS_MIN,
    parameter int BOT_POS_MAX     = pong_pkg::BOT_POS_MAX,
    parameter int P_INIT          = 15,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int MOVE_SPEED      = 1250000
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    input  logic                     i_Up_Raw,
    input  logic                     i_Down_Raw,
    input  logic                     i_Game_Active,
    input  logic [$clog2(HMAX)-1:0]  i_H_count,
    input  logic [$clog2(VMAX)-1:0]  i_V_count,
    output logic [$clog2(WIDTH)-1:0] o_Paddle_Pos,
    output logic                     o_Draw_Paddle
);

    import pong_pkg::*;

    localparam int HW        = $clog2(HMAX);
    localparam int VW        = $clog2(VMAX);
    localparam int PW        = $clog2(WIDTH);
    localparam int SW        = $clog2(MOVE_SPEED + 1);
    // the bottom tile never lies below the playfield height
    localparam int FIELD_BOT = (BOT_POS_MAX < HEIGHT) ? BOT_POS_MAX : HEIGHT;
    localparam int POS_MIN   = TOP_POS_MIN + PADDLE_HALF;
    localparam int POS_MAX   = FIELD_BOT - PADDLE_HALF;
    localparam int H_LO      = (PADDLE_H_POS - 1) * PIXEL_SIZE;
    localparam int H_HI      = PADDLE_H_POS * PIXEL_SIZE;

    logic          w_db_up;
    logic          w_db_dn;
    logic          w_up_req;
    logic          w_dn_req;
    logic          w_lost;
    paddle_state_t r_state;
    logic [SW-1:0] r_cnt;
    logic          r_dir_up;
    logic [PW-1:0] r_pos;
    logic          r_draw;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Raw   (i_Up_Raw),
        .o_Level (w_db_up)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Raw   (i_Down_Raw),
        .o_Level (w_db_dn)
    );

    assign w_up_req = w_db_up & ~w_db_dn;
    assign w_dn_req = w_db_dn & ~w_db_up;
    // request dropped or flipped relative to the direction latched in STEP
    assign w_lost   = r_dir_up ? ~w_up_req : ~w_dn_req;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_state  <= PADDLE_IDLE;
            r_cnt    <= '0;
            r_dir_up <= 1'b0;
            r_pos    <= PW'(P_INIT);
        end else begin
            case (r_state)
                PADDLE_IDLE: begin
                    r_cnt <= '0;
                    if ((w_up_req | w_dn_req) & i_Game_Active)
                        r_state <= PADDLE_STEP;
                end
                PADDLE_STEP: begin
                    // game-active is deliberately ignored here: a step already
                    // committed by IDLE is always applied
                    r_cnt    <= '0;
                    r_dir_up <= w_up_req;
                    if (w_up_req && (r_pos > PW'(POS_MIN)))
                        r_pos <= r_pos - PW'(1);
                    else if (w_dn_req && (r_pos < PW'(POS_MAX)))
                        r_pos <= r_pos + PW'(1);
                    r_state <= PADDLE_HOLD;
                end
                PADDLE_HOLD: begin
                    if (!i_Game_Active || w_lost) begin
                        r_cnt   <= '0;
                        r_state <= PADDLE_IDLE;
                    end else if (r_cnt == SW'(MOVE_SPEED - 1)) begin
                        r_cnt   <= '0;
                        r_state <= PADDLE_STEP;
                    end else begin
                        r_cnt <= r_cnt + SW'(1);
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= PADDLE_IDLE;
                end
            endcase
        end
    end

    // Vertical bounds are one bit wider than the counter so pos-HALF-1
    // cannot wrap at the top clamp.
    logic [VW:0] w_pos_ext;
    logic [VW:0] w_v_lo;
    logic [VW:0] w_v_hi;
    logic [VW:0] w_v;
    logic [HW:0] w_h;
    logic        w_in_h;
    logic        w_in_v;

    assign w_pos_ext = (VW+1)'(r_pos);
    assign w_v_lo    = (w_pos_ext - (VW+1)'(PADDLE_HALF + 1)) * (VW+1)'(PIXEL_SIZE);
    assign w_v_hi    = (w_pos_ext + (VW+1)'(PADDLE_HALF)) * (VW+1)'(PIXEL_SIZE);
    assign w_v       = {1'b0, i_V_count};
    assign w_h       = {1'b0, i_H_count};
    assign w_in_h    = (w_h > (HW+1)'(H_LO)) && (w_h < (HW+1)'(H_HI));
    assign w_in_v    = (w_v > w_v_lo) && (w_v < w_v_hi);

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) r_draw <= 1'b0;
        else         r_draw <= w_in_h & w_in_v;
    end

    assign o_Paddle_Pos  = r_pos;
    assign o_Draw_Paddle = r_draw;

endmodule
